// File: rtl/register_file.sv
// Register file for the single-cycle 64-bit CPU datapath.
// It holds NUM_REGS x DATA_WIDTH registers and has two combinational read
// ports and one write port clocked on the rising edge.
// Optional feature macro: ZERO_REG_EN makes register 0 a hardwired zero.
// Reads do not bypass writes: a read of the write target returns the old
// value until the clock edge that performs the write.
module register_file #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  write_en;

    // Write qualification; with the zero register, writes to address 0 are dropped
`ifdef ZERO_REG_EN
    assign write_en = regWrite && (writeRegister != ADDR_WIDTH'(0));
`else
    assign write_en = regWrite;
`endif

    // Register array: synchronous clear takes priority over the write port
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[writeRegister] <= writeData;
        end
    end

    // Combinational read ports, zero latency, no write bypass
`ifdef ZERO_REG_EN
    assign readData1 = (readRegister1 == ADDR_WIDTH'(0)) ? '0 : regs[readRegister1];
    assign readData2 = (readRegister2 == ADDR_WIDTH'(0)) ? '0 : regs[readRegister2];
`else
    assign readData1 = regs[readRegister1];
    assign readData2 = regs[readRegister2];
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; honours ZERO_REG_EN for the register-0 case.
module tb_register_file;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] readRegister1;
    logic [AW-1:0] readRegister2;
    logic [AW-1:0] writeRegister;
    logic [DW-1:0] writeData;
    logic          regWrite;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;

    int checks = 0;
    int errors = 0;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .regWrite      (regWrite),
        .readData1     (readData1),
        .readData2     (readData2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle past it before anything is sampled or driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] big;
        logic [DW-1:0] exp_r0;
        big = 64'hDEADBEEF_CAFEF00D;
`ifdef ZERO_REG_EN
        exp_r0 = 64'd0;
`else
        exp_r0 = 64'd8;
`endif
        reset = 1'b0; regWrite = 1'b0;
        readRegister1 = '0; readRegister2 = '0; writeRegister = '0; writeData = '0;
        #2;

        // 1: reset clears everything
        reset = 1'b1; tick(); reset = 1'b0;
        readRegister1 = 5'd0; readRegister2 = 5'd31; #1;
        check("rst_rd1_r0", readData1, 64'd0);
        check("rst_rd2_r31", readData2, 64'd0);

        // 2: regWrite low leaves reg 0 untouched
        regWrite = 1'b0; writeRegister = 5'd0; writeData = 64'd8;
        tick(); tick();
        check("nowe_r0", readData1, 64'd0);

        // 3: write reg 0
        regWrite = 1'b1; tick(); regWrite = 1'b0; #1;
        check("wr_r0", readData1, exp_r0);

        // 4: reg 31 holds old value before the edge, new value after, on both ports
        readRegister1 = 5'd31; readRegister2 = 5'd31;
        writeRegister = 5'd31; writeData = big; regWrite = 1'b1; #1;
        check("pre_r31_p1", readData1, 64'd0);
        check("pre_r31_p2", readData2, 64'd0);
        tick(); regWrite = 1'b0; #1;
        check("post_r31_p1", readData1, big);
        check("post_r31_p2", readData2, big);

        // 5: consecutive writes and same-cycle address swap
        regWrite = 1'b1; writeRegister = 5'd3; writeData = 64'd5; tick();
        writeRegister = 5'd4; writeData = 64'd7; tick();
        regWrite = 1'b0;
        readRegister1 = 5'd3; readRegister2 = 5'd4; #1;
        check("r3_p1", readData1, 64'd5);
        check("r4_p2", readData2, 64'd7);
        readRegister1 = 5'd4; readRegister2 = 5'd3; #1;
        check("swap_r4_p1", readData1, 64'd7);
        check("swap_r3_p2", readData2, 64'd5);

        // Read-during-write on port 2 to reg 3: old value until the edge
        regWrite = 1'b1; writeRegister = 5'd3; writeData = 64'd11; #1;
        check("rdw_pre_r3", readData2, 64'd5);
        tick(); regWrite = 1'b0; #1;
        check("rdw_post_r3", readData2, 64'd11);
        check("rdw_r4_kept", readData1, 64'd7);

        // Unknown address/data with regWrite low changes nothing
        writeRegister = 'x; writeData = 'x; tick(); tick();
        readRegister1 = 5'd31; readRegister2 = 5'd3; #1;
        check("x_r31", readData1, big);
        check("x_r3", readData2, 64'd11);
        readRegister1 = 5'd0; #1;
        check("x_r0", readData1, exp_r0);

        // 6: reset wins over a same-edge write, every register reads 0
        reset = 1'b1; regWrite = 1'b1; writeRegister = 5'd3; writeData = 64'd9;
        tick(); reset = 1'b0; regWrite = 1'b0;
        readRegister1 = 5'd3; readRegister2 = 5'd3; #1;
        check("rst_pri_r3", readData1, 64'd0);
        for (int i = 0; i < 32; i++) begin
            readRegister1 = AW'(i); readRegister2 = AW'(31 - i); #1;
            check($sformatf("clr_p1_r%0d", i), readData1, 64'd0);
            check($sformatf("clr_p2_r%0d", 31 - i), readData2, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
